// File: rtl/arccot_search_pkg.sv
// Shared constants, state encoding and cotangent table for the arccot binary searcher.
package arccot_search_pkg;

    localparam int unsigned SEARCH_STEPS = 7;
    localparam int unsigned MAX_DEG      = 90;
    localparam int unsigned DATA_WIDTH   = 64;
    localparam int unsigned MAG_WIDTH    = 63;
    localparam int unsigned IDX_WIDTH    = 7;
    localparam int unsigned STEP_WIDTH   = 3;
    localparam int unsigned EXP_WIDTH    = 11;
    localparam int unsigned MANT_WIDTH   = 52;

    localparam logic [EXP_WIDTH-1:0] EXP_MASK = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] deg;
        logic [1:0]            quadrant;
        logic                  exact;
        logic                  err;
    } result_t;

    // cot(n deg) as IEEE-754 doubles; entry 0 is +Inf, 45 is exactly 1.0, 90 is +0.
    localparam logic [63:0] COTANGENT_DEG_00 = 64'h7FF0000000000000;
    localparam logic [63:0] COTANGENT_DEG_01 = $realtobits(57.289961630759876);
    localparam logic [63:0] COTANGENT_DEG_02 = $realtobits(28.636253282915515);
    localparam logic [63:0] COTANGENT_DEG_03 = $realtobits(19.08113668772816);
    localparam logic [63:0] COTANGENT_DEG_04 = $realtobits(14.300666256711896);
    localparam logic [63:0] COTANGENT_DEG_05 = $realtobits(11.430052302761348);
    localparam logic [63:0] COTANGENT_DEG_06 = $realtobits(9.514364454222587);
    localparam logic [63:0] COTANGENT_DEG_07 = $realtobits(8.144346427974593);
    localparam logic [63:0] COTANGENT_DEG_08 = $realtobits(7.115369722384207);
    localparam logic [63:0] COTANGENT_DEG_09 = $realtobits(6.313751514675041);
    localparam logic [63:0] COTANGENT_DEG_10 = $realtobits(5.671281819617707);
    localparam logic [63:0] COTANGENT_DEG_11 = $realtobits(5.144554015970307);
    localparam logic [63:0] COTANGENT_DEG_12 = $realtobits(4.704630109478451);
    localparam logic [63:0] COTANGENT_DEG_13 = $realtobits(4.331475874284157);
    localparam logic [63:0] COTANGENT_DEG_14 = $realtobits(4.0107809335358455);
    localparam logic [63:0] COTANGENT_DEG_15 = $realtobits(3.7320508075688776);
    localparam logic [63:0] COTANGENT_DEG_16 = $realtobits(3.4874144438409087);
    localparam logic [63:0] COTANGENT_DEG_17 = $realtobits(3.2708526184841404);
    localparam logic [63:0] COTANGENT_DEG_18 = $realtobits(3.0776835371752527);
    localparam logic [63:0] COTANGENT_DEG_19 = $realtobits(2.904210877675822);
    localparam logic [63:0] COTANGENT_DEG_20 = $realtobits(2.7474774194546216);
    localparam logic [63:0] COTANGENT_DEG_21 = $realtobits(2.6050890646938005);
    localparam logic [63:0] COTANGENT_DEG_22 = $realtobits(2.475086853416296);
    localparam logic [63:0] COTANGENT_DEG_23 = $realtobits(2.355852365823753);
    localparam logic [63:0] COTANGENT_DEG_24 = $realtobits(2.2460367739042164);
    localparam logic [63:0] COTANGENT_DEG_25 = $realtobits(2.1445069205095586);
    localparam logic [63:0] COTANGENT_DEG_26 = $realtobits(2.050303841579296);
    localparam logic [63:0] COTANGENT_DEG_27 = $realtobits(1.9626105055051504);
    localparam logic [63:0] COTANGENT_DEG_28 = $realtobits(1.8807264653463318);
    localparam logic [63:0] COTANGENT_DEG_29 = $realtobits(1.8040477552714236);
    localparam logic [63:0] COTANGENT_DEG_30 = $realtobits(1.7320508075688767);
    localparam logic [63:0] COTANGENT_DEG_31 = $realtobits(1.6642794823505173);
    localparam logic [63:0] COTANGENT_DEG_32 = $realtobits(1.6003345290410506);
    localparam logic [63:0] COTANGENT_DEG_33 = $realtobits(1.5398649638145827);
    localparam logic [63:0] COTANGENT_DEG_34 = $realtobits(1.4825609685127403);
    localparam logic [63:0] COTANGENT_DEG_35 = $realtobits(1.4281480067421144);
    localparam logic [63:0] COTANGENT_DEG_36 = $realtobits(1.3763819204711734);
    localparam logic [63:0] COTANGENT_DEG_37 = $realtobits(1.3270448216204098);
    localparam logic [63:0] COTANGENT_DEG_38 = $realtobits(1.2799416321930788);
    localparam logic [63:0] COTANGENT_DEG_39 = $realtobits(1.2348971565350515);
    localparam logic [63:0] COTANGENT_DEG_40 = $realtobits(1.19175359259421);
    localparam logic [63:0] COTANGENT_DEG_41 = $realtobits(1.1503684072210094);
    localparam logic [63:0] COTANGENT_DEG_42 = $realtobits(1.1106125148291928);
    localparam logic [63:0] COTANGENT_DEG_43 = $realtobits(1.0723687100246826);
    localparam logic [63:0] COTANGENT_DEG_44 = $realtobits(1.0355303137905696);
    localparam logic [63:0] COTANGENT_DEG_45 = 64'h3FF0000000000000;
    localparam logic [63:0] COTANGENT_DEG_46 = $realtobits(0.9656887748070739);
    localparam logic [63:0] COTANGENT_DEG_47 = $realtobits(0.9325150861376615);
    localparam logic [63:0] COTANGENT_DEG_48 = $realtobits(0.9004040442978399);
    localparam logic [63:0] COTANGENT_DEG_49 = $realtobits(0.8692867378162265);
    localparam logic [63:0] COTANGENT_DEG_50 = $realtobits(0.8390996311772799);
    localparam logic [63:0] COTANGENT_DEG_51 = $realtobits(0.8097840331950071);
    localparam logic [63:0] COTANGENT_DEG_52 = $realtobits(0.7812856265067173);
    localparam logic [63:0] COTANGENT_DEG_53 = $realtobits(0.7535540501027942);
    localparam logic [63:0] COTANGENT_DEG_54 = $realtobits(0.7265425280053608);
    localparam logic [63:0] COTANGENT_DEG_55 = $realtobits(0.7002075382097097);
    localparam logic [63:0] COTANGENT_DEG_56 = $realtobits(0.6745085168424265);
    localparam logic [63:0] COTANGENT_DEG_57 = $realtobits(0.6494075931975104);
    localparam logic [63:0] COTANGENT_DEG_58 = $realtobits(0.6248693519093275);
    localparam logic [63:0] COTANGENT_DEG_59 = $realtobits(0.6008606190275604);
    localparam logic [63:0] COTANGENT_DEG_60 = $realtobits(0.5773502691896257);
    localparam logic [63:0] COTANGENT_DEG_61 = $realtobits(0.554309051452769);
    localparam logic [63:0] COTANGENT_DEG_62 = $realtobits(0.5317094316614788);
    localparam logic [63:0] COTANGENT_DEG_63 = $realtobits(0.5095254494944288);
    localparam logic [63:0] COTANGENT_DEG_64 = $realtobits(0.48773258856586144);
    localparam logic [63:0] COTANGENT_DEG_65 = $realtobits(0.4663076581549986);
    localparam logic [63:0] COTANGENT_DEG_66 = $realtobits(0.4452286853085361);
    localparam logic [63:0] COTANGENT_DEG_67 = $realtobits(0.4244748162096047);
    localparam logic [63:0] COTANGENT_DEG_68 = $realtobits(0.4040262258351568);
    localparam logic [63:0] COTANGENT_DEG_69 = $realtobits(0.3838640350354158);
    localparam logic [63:0] COTANGENT_DEG_70 = $realtobits(0.36397023426620234);
    localparam logic [63:0] COTANGENT_DEG_71 = $realtobits(0.34432761328966527);
    localparam logic [63:0] COTANGENT_DEG_72 = $realtobits(0.3249196962329063);
    localparam logic [63:0] COTANGENT_DEG_73 = $realtobits(0.30573068145866033);
    localparam logic [63:0] COTANGENT_DEG_74 = $realtobits(0.2867453857588079);
    localparam logic [63:0] COTANGENT_DEG_75 = $realtobits(0.2679491924311227);
    localparam logic [63:0] COTANGENT_DEG_76 = $realtobits(0.2493280028431807);
    localparam logic [63:0] COTANGENT_DEG_77 = $realtobits(0.2308681911255631);
    localparam logic [63:0] COTANGENT_DEG_78 = $realtobits(0.2125565616700221);
    localparam logic [63:0] COTANGENT_DEG_79 = $realtobits(0.19438030913771848);
    localparam logic [63:0] COTANGENT_DEG_80 = $realtobits(0.17632698070846498);
    localparam logic [63:0] COTANGENT_DEG_81 = $realtobits(0.15838444032453627);
    localparam logic [63:0] COTANGENT_DEG_82 = $realtobits(0.14054083470239145);
    localparam logic [63:0] COTANGENT_DEG_83 = $realtobits(0.1227845609029046);
    localparam logic [63:0] COTANGENT_DEG_84 = $realtobits(0.10510423526567646);
    localparam logic [63:0] COTANGENT_DEG_85 = $realtobits(0.08748866352592401);
    localparam logic [63:0] COTANGENT_DEG_86 = $realtobits(0.06992681194351041);
    localparam logic [63:0] COTANGENT_DEG_87 = $realtobits(0.05240777928304121);
    localparam logic [63:0] COTANGENT_DEG_88 = $realtobits(0.03492076949174773);
    localparam logic [63:0] COTANGENT_DEG_89 = $realtobits(0.017455064928217585);
    localparam logic [63:0] COTANGENT_DEG_90 = 64'h0000000000000000;

endpackage

// File: rtl/cotangent_rom.sv
// Combinational cotangent magnitude ROM indexed by whole degrees; zero past 90.
module cotangent_rom
    import arccot_search_pkg::*;
(
    input  logic [IDX_WIDTH-1:0] idx,
    output logic [MAG_WIDTH-1:0] mag_c
);

    always_comb begin
        mag_c = '0;
        case (idx)
            7'd0:  mag_c = COTANGENT_DEG_00[62:0];
            7'd1:  mag_c = COTANGENT_DEG_01[62:0];
            7'd2:  mag_c = COTANGENT_DEG_02[62:0];
            7'd3:  mag_c = COTANGENT_DEG_03[62:0];
            7'd4:  mag_c = COTANGENT_DEG_04[62:0];
            7'd5:  mag_c = COTANGENT_DEG_05[62:0];
            7'd6:  mag_c = COTANGENT_DEG_06[62:0];
            7'd7:  mag_c = COTANGENT_DEG_07[62:0];
            7'd8:  mag_c = COTANGENT_DEG_08[62:0];
            7'd9:  mag_c = COTANGENT_DEG_09[62:0];
            7'd10: mag_c = COTANGENT_DEG_10[62:0];
            7'd11: mag_c = COTANGENT_DEG_11[62:0];
            7'd12: mag_c = COTANGENT_DEG_12[62:0];
            7'd13: mag_c = COTANGENT_DEG_13[62:0];
            7'd14: mag_c = COTANGENT_DEG_14[62:0];
            7'd15: mag_c = COTANGENT_DEG_15[62:0];
            7'd16: mag_c = COTANGENT_DEG_16[62:0];
            7'd17: mag_c = COTANGENT_DEG_17[62:0];
            7'd18: mag_c = COTANGENT_DEG_18[62:0];
            7'd19: mag_c = COTANGENT_DEG_19[62:0];
            7'd20: mag_c = COTANGENT_DEG_20[62:0];
            7'd21: mag_c = COTANGENT_DEG_21[62:0];
            7'd22: mag_c = COTANGENT_DEG_22[62:0];
            7'd23: mag_c = COTANGENT_DEG_23[62:0];
            7'd24: mag_c = COTANGENT_DEG_24[62:0];
            7'd25: mag_c = COTANGENT_DEG_25[62:0];
            7'd26: mag_c = COTANGENT_DEG_26[62:0];
            7'd27: mag_c = COTANGENT_DEG_27[62:0];
            7'd28: mag_c = COTANGENT_DEG_28[62:0];
            7'd29: mag_c = COTANGENT_DEG_29[62:0];
            7'd30: mag_c = COTANGENT_DEG_30[62:0];
            7'd31: mag_c = COTANGENT_DEG_31[62:0];
            7'd32: mag_c = COTANGENT_DEG_32[62:0];
            7'd33: mag_c = COTANGENT_DEG_33[62:0];
            7'd34: mag_c = COTANGENT_DEG_34[62:0];
            7'd35: mag_c = COTANGENT_DEG_35[62:0];
            7'd36: mag_c = COTANGENT_DEG_36[62:0];
            7'd37: mag_c = COTANGENT_DEG_37[62:0];
            7'd38: mag_c = COTANGENT_DEG_38[62:0];
            7'd39: mag_c = COTANGENT_DEG_39[62:0];
            7'd40: mag_c = COTANGENT_DEG_40[62:0];
            7'd41: mag_c = COTANGENT_DEG_41[62:0];
            7'd42: mag_c = COTANGENT_DEG_42[62:0];
            7'd43: mag_c = COTANGENT_DEG_43[62:0];
            7'd44: mag_c = COTANGENT_DEG_44[62:0];
            7'd45: mag_c = COTANGENT_DEG_45[62:0];
            7'd46: mag_c = COTANGENT_DEG_46[62:0];
            7'd47: mag_c = COTANGENT_DEG_47[62:0];
            7'd48: mag_c = COTANGENT_DEG_48[62:0];
            7'd49: mag_c = COTANGENT_DEG_49[62:0];
            7'd50: mag_c = COTANGENT_DEG_50[62:0];
            7'd51: mag_c = COTANGENT_DEG_51[62:0];
            7'd52: mag_c = COTANGENT_DEG_52[62:0];
            7'd53: mag_c = COTANGENT_DEG_53[62:0];
            7'd54: mag_c = COTANGENT_DEG_54[62:0];
            7'd55: mag_c = COTANGENT_DEG_55[62:0];
            7'd56: mag_c = COTANGENT_DEG_56[62:0];
            7'd57: mag_c = COTANGENT_DEG_57[62:0];
            7'd58: mag_c = COTANGENT_DEG_58[62:0];
            7'd59: mag_c = COTANGENT_DEG_59[62:0];
            7'd60: mag_c = COTANGENT_DEG_60[62:0];
            7'd61: mag_c = COTANGENT_DEG_61[62:0];
            7'd62: mag_c = COTANGENT_DEG_62[62:0];
            7'd63: mag_c = COTANGENT_DEG_63[62:0];
            7'd64: mag_c = COTANGENT_DEG_64[62:0];
            7'd65: mag_c = COTANGENT_DEG_65[62:0];
            7'd66: mag_c = COTANGENT_DEG_66[62:0];
            7'd67: mag_c = COTANGENT_DEG_67[62:0];
            7'd68: mag_c = COTANGENT_DEG_68[62:0];
            7'd69: mag_c = COTANGENT_DEG_69[62:0];
            7'd70: mag_c = COTANGENT_DEG_70[62:0];
            7'd71: mag_c = COTANGENT_DEG_71[62:0];
            7'd72: mag_c = COTANGENT_DEG_72[62:0];
            7'd73: mag_c = COTANGENT_DEG_73[62:0];
            7'd74: mag_c = COTANGENT_DEG_74[62:0];
            7'd75: mag_c = COTANGENT_DEG_75[62:0];
            7'd76: mag_c = COTANGENT_DEG_76[62:0];
            7'd77: mag_c = COTANGENT_DEG_77[62:0];
            7'd78: mag_c = COTANGENT_DEG_78[62:0];
            7'd79: mag_c = COTANGENT_DEG_79[62:0];
            7'd80: mag_c = COTANGENT_DEG_80[62:0];
            7'd81: mag_c = COTANGENT_DEG_81[62:0];
            7'd82: mag_c = COTANGENT_DEG_82[62:0];
            7'd83: mag_c = COTANGENT_DEG_83[62:0];
            7'd84: mag_c = COTANGENT_DEG_84[62:0];
            7'd85: mag_c = COTANGENT_DEG_85[62:0];
            7'd86: mag_c = COTANGENT_DEG_86[62:0];
            7'd87: mag_c = COTANGENT_DEG_87[62:0];
            7'd88: mag_c = COTANGENT_DEG_88[62:0];
            7'd89: mag_c = COTANGENT_DEG_89[62:0];
            7'd90: mag_c = COTANGENT_DEG_90[62:0];
            default: mag_c = '0;
        endcase
    end

endmodule

// File: rtl/arccot_search.sv
// Inverse cotangent: binary-searches the degree table for the floor degree of |x|, one probe per cycle.
module arccot_search
    import arccot_search_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [63:0]           data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] deg_out,
    output logic [1:0]            quadrant_out,
    output logic                  exact_out,
    output logic                  err_out
);

    state_t                 state, state_next;
    logic [MAG_WIDTH-1:0]   mag, mag_next;
    logic                   sign, sign_next;
    logic [IDX_WIDTH-1:0]   lo, lo_next, hi, hi_next;
    logic [STEP_WIDTH-1:0]  step, step_next;
    logic                   lo_hit, lo_hit_next;
    logic                   special, special_next;
    logic                   nan, nan_next;
    result_t                res, res_next;
    logic                   in_ready_next, out_valid_next;

    logic [IDX_WIDTH:0]     mid_sum_c;
    logic [IDX_WIDTH-1:0]   mid_c;
    logic [MAG_WIDTH-1:0]   rom_mag_c;
    logic [IDX_WIDTH-1:0]   lo_upd_c;
    logic                   lo_hit_upd_c;
    logic [EXP_WIDTH-1:0]   in_exp_c;
    logic [MANT_WIDTH-1:0]  in_mant_c;

    assign mid_sum_c = (IDX_WIDTH+1)'(lo) + (IDX_WIDTH+1)'(hi) + (IDX_WIDTH+1)'(1);
    assign mid_c     = mid_sum_c[IDX_WIDTH:1];
    assign in_exp_c  = data_in[62:52];
    assign in_mant_c = data_in[51:0];

    cotangent_rom u_rom (
        .idx   (mid_c),
        .mag_c (rom_mag_c)
    );

    // lo_hit tracks whether the entry at lo equals m, so no second ROM read is needed at the end.
    always_comb begin
        lo_upd_c     = lo;
        lo_hit_upd_c = lo_hit;
        if (!special && (lo != hi)) begin
            if (rom_mag_c >= mag) begin
                lo_upd_c     = mid_c;
                lo_hit_upd_c = (rom_mag_c == mag);
            end
        end
    end

    always_comb begin
        state_next   = state;
        mag_next     = mag;
        sign_next    = sign;
        lo_next      = lo;
        hi_next      = hi;
        step_next    = step;
        lo_hit_next  = lo_hit;
        special_next = special;
        nan_next     = nan;
        res_next     = res;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    mag_next     = data_in[62:0];
                    sign_next    = data_in[63];
                    lo_next      = '0;
                    hi_next      = IDX_WIDTH'(MAX_DEG);
                    lo_hit_next  = 1'b0;
                    special_next = (in_exp_c == EXP_MASK);
                    nan_next     = (in_exp_c == EXP_MASK) && (in_mant_c != '0);
                    // NaN/Inf skip straight to the final step so they finish one cycle later.
                    step_next    = (in_exp_c == EXP_MASK) ? STEP_WIDTH'(SEARCH_STEPS - 1) : '0;
                    state_next   = SEARCH;
                end
            end
            SEARCH: begin
                lo_next     = lo_upd_c;
                lo_hit_next = lo_hit_upd_c;
                if (!special && (lo != hi) && (rom_mag_c < mag)) begin
                    hi_next = mid_c - IDX_WIDTH'(1);
                end
                step_next = step + STEP_WIDTH'(1);
                if (step == STEP_WIDTH'(SEARCH_STEPS - 1)) begin
                    res_next.deg      = special ? '0 : DATA_WIDTH'(lo_upd_c);
                    res_next.exact    = special ? !nan : lo_hit_upd_c;
                    res_next.err      = nan;
                    res_next.quadrant = (sign && (mag != '0) && !nan) ? 2'd1 : 2'd0;
                    state_next        = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            mag       <= '0;
            sign      <= 1'b0;
            lo        <= '0;
            hi        <= '0;
            step      <= '0;
            lo_hit    <= 1'b0;
            special   <= 1'b0;
            nan       <= 1'b0;
            res       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            mag       <= mag_next;
            sign      <= sign_next;
            lo        <= lo_next;
            hi        <= hi_next;
            step      <= step_next;
            lo_hit    <= lo_hit_next;
            special   <= special_next;
            nan       <= nan_next;
            res       <= res_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
        end
    end

    assign deg_out      = res.deg;
    assign quadrant_out = res.quadrant;
    assign exact_out    = res.exact;
    assign err_out      = res.err;

endmodule

// File: tb/tb_arccot_search.sv
// Directed bench for arccot_search: known cotangent inputs, bypass latency, backpressure and reset abort.
module tb_arccot_search;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] deg_out;
    logic [1:0]  quadrant_out;
    logic        exact_out;
    logic        err_out;

    int errors = 0;
    int checks = 0;

    arccot_search dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .deg_out      (deg_out),
        .quadrant_out (quadrant_out),
        .exact_out    (exact_out),
        .err_out      (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for the result, check it and the latency, then complete the handshake.
    task automatic run(input string tag, input logic [63:0] x, input int exp_deg,
                       input int exp_quad, input int exp_exact, input int exp_err,
                       input int exp_lat, input int hold);
        int lat;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        data_in  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".deg"}, deg_out, 64'(exp_deg));
        check({tag, ".quad"}, 64'(quadrant_out), 64'(exp_quad));
        check({tag, ".exact"}, 64'(exact_out), 64'(exp_exact));
        check({tag, ".err"}, 64'(err_out), 64'(exp_err));
        check({tag, ".busy"}, 64'(in_ready), 64'd0);
        // Backpressure: outputs must hold while a second request is presented and ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            data_in  = 64'h3FF0000000000000;
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_deg"}, deg_out, 64'(exp_deg));
            check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".ack_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".ack_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.deg", deg_out, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rel.in_ready", 64'(in_ready), 64'd1);

        run("one",     64'h3FF0000000000000, 45, 0, 1, 0, 7, 0);
        run("two",     64'h4000000000000000, 26, 0, 0, 0, 7, 0);
        run("neg_one", 64'hBFF0000000000000, 45, 1, 1, 0, 7, 0);
        run("half",    64'h3FE0000000000000, 63, 0, 0, 0, 7, 0);
        run("zero",    64'h0000000000000000, 90, 0, 1, 0, 7, 0);
        run("neg_zero",64'h8000000000000000, 90, 0, 1, 0, 7, 0);
        run("denorm",  64'h0000000000000001, 89, 0, 0, 0, 7, 0);
        run("big",     64'h4059000000000000, 0,  0, 0, 0, 7, 0);
        run("nan",     64'h7FF8000000000000, 0,  0, 0, 1, 1, 0);
        run("inf",     64'h7FF0000000000000, 0,  0, 1, 0, 1, 0);
        run("bp",      64'hC000000000000000, 26, 1, 0, 0, 7, 5);

        // The ignored request during backpressure must not have been latched.
        repeat (10) @(posedge clk);
        #1;
        check("bp.no_ghost", 64'(out_valid), 64'd0);
        check("bp.idle", 64'(in_ready), 64'd1);

        // Reset at E3 of a search aborts it.
        in_valid = 1'b1;
        data_in  = 64'h3FF0000000000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.in_ready", 64'(in_ready), 64'd0);
        check("abort.deg", deg_out, 64'd0);
        check("abort.quad", 64'(quadrant_out), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("abort.idle", 64'(in_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        check("abort.discarded", 64'(out_valid), 64'd0);

        run("after_rst", 64'h3FF0000000000000, 45, 0, 1, 0, 7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arccot_search.md
# arccot_search

Inverse of the cotangent lookup path: accepts an IEEE-754 double and returns the integer degree (0..90) whose tabulated cotangent brackets it, plus the quadrant implied by the sign. Runs a fixed-length binary search over the same 91-entry `COTANGENT_DEG_xx` constants, one probe per cycle. Sits behind the FPU result bus, next to the forward trig LUTs, with valid/ready handshakes on both sides.

## Interface
- `SEARCH_STEPS`, 7: binary-search iterations; ceil(log2(91)).
- `MAX_DEG`, 90: highest table index.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low; clock `clk`.
- `in_valid` in 1: `data_in` is valid.
- `in_ready` out 1: block can accept; high only in IDLE.
- `data_in` in 64: IEEE-754 double, cotangent value.
- `out_valid` out 1: result valid; held until `out_ready`.
- `out_ready` in 1: consumer takes the result.
- `deg_out` out `DATA_WIDTH`: floor degree, 0..90.
- `quadrant_out` out 2: 2'd0 for non-negative input, 2'd1 for negative input. The angle is 180 - `deg_out`.
- `exact_out` out 1: table entry equals |x|.
- `err_out` out 1: input was NaN.

## Operation
- Magnitude handling:
  - m = `data_in[62:0]`. Non-negative doubles order as unsigned integers, so every compare is a 63-bit unsigned compare.
  - Table entries are compared only on bits [62:0].
- Result definition: `deg_out` = largest i in 0..90 with table[i] >= m. The table is strictly decreasing, table[90] = 0 and table[45] = 0x3FF0000000000000.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, latch m and the sign.
  - NaN input (exp = 0x7FF, mantissa != 0) → DONE with err=1, deg=0, exact=0, quadrant=0.
  - ±Inf input (exp = 0x7FF, mantissa = 0) → DONE with deg=0, exact=1, err=0.
  - Otherwise load lo=0, hi=90, step=0 and go to SEARCH.
- SEARCH, each cycle:
  - mid = (lo+hi+1)>>1, read ROM[mid].
  - If ROM[mid] >= m, lo ← mid; else hi ← mid-1.
  - If lo == hi already, hold (no-op).
  - step increments each cycle. After step reaches SEARCH_STEPS-1, set deg=lo and exact=(ROM[lo]==m), then go to DONE.
  - Entry 0 is never probed, since mid >= 1. lo=0 is the default result.
- Quadrant: sign=1 and m != 0 gives quadrant 1. Otherwise quadrant 0, so -0.0 reports quadrant 0.
- DONE:
  - `out_valid` = 1 and outputs are stable.
  - On `out_ready`, go to IDLE; `in_ready` rises the next cycle.
  - An input never overlaps an output.
- Reset values: `in_ready`=0 during reset, 1 the cycle after release. `out_valid`=0, `deg_out`=0, `quadrant_out`=0, `exact_out`=0, `err_out`=0. State = IDLE.
- Reset mid-SEARCH or mid-DONE aborts the operation and discards the result; the same reset values apply.
- `in_valid` outside IDLE is ignored; the source must hold it.

## Timing
- Accept at edge E0 (`in_valid` & `in_ready`).
- Normal path: SEARCH occupies E1..E7. `out_valid` is high after E7, i.e. in the 8th cycle after acceptance.
- NaN/Inf bypass: `out_valid` is high after E1.
- The output handshake completes at the edge where `out_valid` & `out_ready`. `in_ready` is high after that edge.
- Peak throughput: one result per 9 cycles on the normal path.
- The ROM is combinational, so the compare result is registered in the same cycle as the probe.
- No outputs are tri-stated; outputs hold their last value when idle.

## Structure
- Constants go in `defines.v`:
  - `ARCCOT_SEARCH_STEPS` (7), `ARCCOT_MAX_DEG` (90).
  - State encodings IDLE=2'd0, SEARCH=2'd1, DONE=2'd2.
  - NaN/Inf exponent mask 11'h7FF.
  - Reuses the existing `COTANGENT_DEG_00..90` and `DATA_WIDTH`.
- Sub-module `cotangent_rom`: combinational, 7-bit index in, 63-bit magnitude out, entries `COTANGENT_DEG_xx`, 0 for indices > 90. It is shareable with other inverse-trig searchers.
- Top level: FSM, lo/hi/step registers, latched m/sign, output registers.

## Test plan
- x = 0x3FF0000000000000 (1.0) → deg 45, exact 1, quadrant 0, err 0; `out_valid` after E7.
- x = 0x4000000000000000 (2.0) → deg 26 (cot 26° ≈ 2.0503, cot 27° ≈ 1.9626), exact 0, quadrant 0.
- x = 0xBFF0000000000000 (-1.0) → deg 45, exact 1, quadrant 1.
- x = 0x0000000000000000 → deg 90, exact 1. x = 0x8000000000000000 → deg 90, quadrant 0.
- x = 0x7FF8000000000000 (NaN) → err 1, deg 0, `out_valid` after E1. x = 0x7FF0000000000000 (+Inf) → deg 0, exact 1, `out_valid` after E1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles: outputs stable, `in_ready`=0, a second `in_valid` is ignored.
  - Assert `reset_n`=0 at E3 of a search: all outputs zero, IDLE next cycle.
  - A new 1.0 request then returns 45.
